// File: rtl/alu_result_buffer.sv
// Two-entry registered buffer behind the 32-bit ALU: captures Y, flags and sel with
// valid/ready on both sides, plus sticky carry/overflow status and a saturating result count.
module alu_result_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_y,
    input  logic              in_cout,
    input  logic              in_neg,
    input  logic              in_zero,
    input  logic              in_ovf,
    input  logic [3:0]        in_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic [3:0]        out_flags,
    output logic [3:0]        out_sel,
    input  logic              clr_sticky,
    output logic              sticky_cout,
    output logic              sticky_ovf,
    output logic [CNT_W-1:0]  result_cnt
);

    localparam int ENTRY_W = DATA_W + 8;
    localparam logic [1:0] FULL = 2'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [ENTRY_W-1:0] mem_q [0:1];
    logic [ENTRY_W-1:0] mem_d [0:1];
    logic [ENTRY_W-1:0] head_q, head_d;
    logic [ENTRY_W-1:0] in_entry;
    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;
    logic [1:0]         count_q, count_d;
    logic               sticky_cout_q, sticky_cout_d;
    logic               sticky_ovf_q, sticky_ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push, pop;

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_entry  = {in_sel, in_cout, in_neg, in_zero, in_ovf, in_y};

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q] = in_entry;
        end
        wptr_d  = wptr_q ^ push;
        rptr_d  = rptr_q ^ pop;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        // Head register looks ahead at the post-edge slot so out_* never depend on in_*.
        head_d  = (count_d != 2'd0) ? mem_d[rptr_d] : head_q;

        // A set flag on the incoming push overrides a coincident clear.
        sticky_cout_d = (clr_sticky ? 1'b0 : sticky_cout_q) | (push & in_cout);
        sticky_ovf_d  = (clr_sticky ? 1'b0 : sticky_ovf_q)  | (push & in_ovf);
        cnt_d         = push ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q        <= 1'b0;
            rptr_q        <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= '0;
            sticky_cout_q <= 1'b0;
            sticky_ovf_q  <= 1'b0;
            cnt_q         <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            head_q        <= head_d;
            sticky_cout_q <= sticky_cout_d;
            sticky_ovf_q  <= sticky_ovf_d;
            cnt_q         <= cnt_d;
        end
    end

    assign out_y       = head_q[DATA_W-1:0];
    assign out_flags   = head_q[DATA_W+3:DATA_W];
    assign out_sel     = head_q[DATA_W+7:DATA_W+4];
    assign sticky_cout = sticky_cout_q;
    assign sticky_ovf  = sticky_ovf_q;
    assign result_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer (CNT_W=4 so counter saturation is reachable).
module tb_alu_result_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_y;
    logic        in_cout, in_neg, in_zero, in_ovf;
    logic [3:0]  in_sel;
    logic        out_valid, out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_flags, out_sel;
    logic        clr_sticky, sticky_cout, sticky_ovf;
    logic [3:0]  result_cnt;

    alu_result_buffer #(.DATA_W(32), .DEPTH(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
        .in_cout(in_cout), .in_neg(in_neg), .in_zero(in_zero), .in_ovf(in_ovf), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_flags(out_flags), .out_sel(out_sel),
        .clr_sticky(clr_sticky), .sticky_cout(sticky_cout), .sticky_ovf(sticky_ovf),
        .result_cnt(result_cnt)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [39:0] sbq[$];
    int          exp_cnt;

    function automatic logic [39:0] mk(input logic [3:0] sel, input logic c, input logic n,
                                       input logic z, input logic v, input logic [31:0] y);
        return {sel, c, n, z, v, y};
    endfunction

    task automatic drive(input bit v, input logic [39:0] e, input bit ordy, input bit clr);
        in_valid   = v;
        in_y       = e[31:0];
        in_ovf     = e[32];
        in_zero    = e[33];
        in_neg     = e[34];
        in_cout    = e[35];
        in_sel     = e[39:36];
        out_ready  = ordy;
        clr_sticky = clr;
    endtask

    // Reference model update for one clock edge (pop before push keeps order at count=1).
    task automatic model_edge(input bit p, input bit o, input logic [39:0] e);
        if (o) void'(sbq.pop_front());
        if (p) begin
            sbq.push_back(e);
            if (exp_cnt < 15) exp_cnt++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, '0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        sbq.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, '0, 0, 0);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if ({out_sel, out_flags, out_y} !== 40'd0) begin fails++; $display("FAIL reset_out_data got %h want 0", {out_sel, out_flags, out_y}); end
        tests++; if ({sticky_cout, sticky_ovf} !== 2'b00) begin fails++; $display("FAIL reset_sticky got %b want 00", {sticky_cout, sticky_ovf}); end
        tests++; if (result_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", result_cnt); end
        do_reset();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        logic [39:0] e;
        bit p, o;
        do_reset();
        e = mk(4'b0000, 0, 0, 0, 0, 32'h0000_00A5);
        for (int k = 0; k < 3; k++) begin
            drive(k == 0, e, 1, 0);
            @(negedge clk);
            tests++; if (out_valid !== (sbq.size() != 0)) begin fails++; $display("FAIL single_out_valid k=%0d got %b want %b", k, out_valid, sbq.size() != 0); end
            if (sbq.size() != 0) begin
                tests++; if ({out_sel, out_flags, out_y} !== sbq[0]) begin fails++; $display("FAIL single_data got %h want %h", {out_sel, out_flags, out_y}, sbq[0]); end
            end
            p = in_valid && (sbq.size() != 2);
            o = out_ready && (sbq.size() != 0);
            model_edge(p, o, e);
            @(posedge clk); #1;
        end
        tests++; if (out_y !== 32'h0000_00A5) begin fails++; $display("FAIL single_hold got %h want 000000a5", out_y); end
        tests++; if (result_cnt !== 4'd1) begin fails++; $display("FAIL single_cnt got %0d want 1", result_cnt); end
    endtask

    task automatic test_backpressure();
        logic [39:0] e;
        bit p, o;
        int idx = 0, npop = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            e = mk(4'h2, 0, 0, 0, 0, 32'(idx + 1));
            drive(idx < 3, e, c >= 4, 0);
            @(negedge clk);
            tests++; if (in_ready !== (sbq.size() != 2)) begin fails++; $display("FAIL bp_in_ready c=%0d got %b want %b", c, in_ready, sbq.size() != 2); end
            tests++; if (out_valid !== (sbq.size() != 0)) begin fails++; $display("FAIL bp_out_valid c=%0d got %b want %b", c, out_valid, sbq.size() != 0); end
            if (sbq.size() != 0) begin
                tests++; if ({out_sel, out_flags, out_y} !== sbq[0]) begin fails++; $display("FAIL bp_data c=%0d got %h want %h", c, {out_sel, out_flags, out_y}, sbq[0]); end
            end
            p = in_valid && (sbq.size() != 2);
            o = out_ready && (sbq.size() != 0);
            if (p) idx++;
            if (o) npop++;
            model_edge(p, o, e);
            @(posedge clk); #1;
        end
        tests++; if (npop != 3) begin fails++; $display("FAIL bp_pops got %0d want 3", npop); end
        tests++; if (result_cnt !== 4'd3) begin fails++; $display("FAIL bp_cnt got %0d want 3", result_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] e;
        bit p, o;
        int npop = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            e = mk(4'h1, k[0], 0, 0, 0, 32'h100 + 32'(k));
            drive(k < 8, e, 1, 0);
            @(negedge clk);
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready k=%0d got %b want 1", k, in_ready); end
            tests++; if (out_valid !== (k >= 1 && k <= 8)) begin fails++; $display("FAIL stream_out_valid k=%0d got %b want %b", k, out_valid, k >= 1 && k <= 8); end
            if (sbq.size() != 0) begin
                tests++; if ({out_sel, out_flags, out_y} !== sbq[0]) begin fails++; $display("FAIL stream_data k=%0d got %h want %h", k, {out_sel, out_flags, out_y}, sbq[0]); end
            end
            p = in_valid && (sbq.size() != 2);
            o = out_ready && (sbq.size() != 0);
            if (o) npop++;
            model_edge(p, o, e);
            @(posedge clk); #1;
        end
        tests++; if (npop != 8) begin fails++; $display("FAIL stream_pops got %0d want 8", npop); end
    endtask

    task automatic test_sticky();
        logic [39:0] ev [5];
        bit          vv [5] = '{1, 1, 0, 1, 1};
        bit          cv [5] = '{0, 0, 1, 1, 1};
        bit          want_ovf [5] = '{1, 1, 0, 1, 0};
        bit          want_cout [5] = '{0, 0, 0, 0, 1};
        bit p, o;
        ev[0] = mk(4'h0, 0, 1, 0, 1, 32'h8000_0000);
        ev[1] = mk(4'h0, 0, 0, 0, 0, 32'h0000_0005);
        ev[2] = mk(4'h0, 1, 0, 0, 1, 32'h0000_0000);
        ev[3] = mk(4'h0, 0, 1, 0, 1, 32'h8000_0001);
        ev[4] = mk(4'h0, 1, 0, 1, 0, 32'h0000_0000);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(vv[k], ev[k], 1, cv[k]);
            @(negedge clk);
            if (sbq.size() != 0) begin
                tests++; if ({out_sel, out_flags, out_y} !== sbq[0]) begin fails++; $display("FAIL sticky_data k=%0d got %h want %h", k, {out_sel, out_flags, out_y}, sbq[0]); end
            end
            p = in_valid && (sbq.size() != 2);
            o = out_ready && (sbq.size() != 0);
            model_edge(p, o, ev[k]);
            @(posedge clk); #1;
            tests++; if (sticky_ovf !== want_ovf[k]) begin fails++; $display("FAIL sticky_ovf k=%0d got %b want %b", k, sticky_ovf, want_ovf[k]); end
            tests++; if (sticky_cout !== want_cout[k]) begin fails++; $display("FAIL sticky_cout k=%0d got %b want %b", k, sticky_cout, want_cout[k]); end
        end
    endtask

    task automatic test_saturation();
        logic [39:0] e;
        bit p, o;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            e = mk(4'h3, 0, 0, 0, 0, 32'(k));
            drive(1, e, 1, 0);
            @(negedge clk);
            p = in_valid && (sbq.size() != 2);
            o = out_ready && (sbq.size() != 0);
            model_edge(p, o, e);
            @(posedge clk); #1;
            tests++; if (result_cnt !== 4'((k + 1 > 15) ? 15 : k + 1)) begin fails++; $display("FAIL sat_cnt k=%0d got %0d want %0d", k, result_cnt, (k + 1 > 15) ? 15 : k + 1); end
        end
        drive(0, '0, 1, 1);
        @(posedge clk); #1;
        tests++; if (result_cnt !== 4'hF) begin fails++; $display("FAIL sat_hold_clr got %0d want 15", result_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, mk(4'h4, 1, 0, 0, 1, 32'h1111_1111), 0, 0);
        @(posedge clk); #1;
        drive(1, mk(4'h4, 1, 0, 0, 1, 32'h2222_2222), 0, 0);
        @(posedge clk); #1;
        drive(0, '0, 0, 0);
        tests++; if ({out_valid, in_ready, sticky_cout, sticky_ovf} !== 4'b1011) begin fails++; $display("FAIL arst_pre got %b want 1011", {out_valid, in_ready, sticky_cout, sticky_ovf}); end
        tests++; if (result_cnt !== 4'd2) begin fails++; $display("FAIL arst_pre_cnt got %0d want 2", result_cnt); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({out_valid, in_ready, sticky_cout, sticky_ovf} !== 4'b0100) begin fails++; $display("FAIL arst_now got %b want 0100", {out_valid, in_ready, sticky_cout, sticky_ovf}); end
        tests++; if (result_cnt !== 4'd0) begin fails++; $display("FAIL arst_cnt got %0d want 0", result_cnt); end
        #2 rst_n = 1'b1;
        sbq.delete();
        exp_cnt = 0;
        drive(0, '0, 1, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_no_replay got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_sticky();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Registered output stage directly downstream of the 32-bit ALU.
- Captures each ALU result (Y plus Cout/Negative/Zero/Overflow and the sel that produced it) into a 2-entry buffer with valid/ready handshakes on both sides.
- Decouples the combinational ALU from the consumer (register-file writeback) and maintains sticky carry/overflow status and a saturating result counter.

Parameters:
- DATA_W, 32, width of the ALU result Y.
- DEPTH, 2, buffer entries. Fixed at 2; other values unsupported.
- CNT_W, 16, width of the accepted-result counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU result on in_* is valid this cycle.
- in_ready  output  1  buffer can accept; transfer when in_valid && in_ready.
- in_y  input  DATA_W  ALU Y.
- in_cout  input  1  ALU Cout.
- in_neg  input  1  ALU Negative.
- in_zero  input  1  ALU Zero.
- in_ovf  input  1  ALU Overflow.
- in_sel  input  4  ALU sel that produced the result.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- out_y  output  DATA_W  head entry Y.
- out_flags  output  4  head entry {Cout, Negative, Zero, Overflow}, MSB first.
- out_sel  output  4  head entry sel.
- clr_sticky  input  1  synchronous clear of the sticky flags.
- sticky_cout  output  1  set once any accepted entry had Cout=1.
- sticky_ovf  output  1  set once any accepted entry had Overflow=1.
- result_cnt  output  CNT_W  number of accepted entries, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, read and write pointers=0.
  - out_valid=0, in_ready=1 (once reset is released), out_y=0, out_flags=0, out_sel=0.
  - sticky_cout=0, sticky_ovf=0, result_cnt=0.
  - Reset asserted mid-transfer discards all entries; nothing is replayed.
- Storage: 2-entry circular buffer, 40 bits per entry {sel, Cout, N, Z, V, Y}. Write and read pointers are 1 bit each and wrap 1→0.
- Occupancy: in_ready = (count != 2), combinational from count only, never from in_valid. out_valid = (count != 0).
- Outputs out_y/out_flags/out_sel are driven from the head-entry register. When count=0 they hold the last popped value.
- Latency: an entry pushed at edge N into an empty buffer gives out_valid=1 with that data after edge N (visible in cycle N+1). There is no combinational in→out path.
- Per edge: push = in_valid && in_ready; pop = out_valid && out_ready.
  - count_next = count + push − pop.
  - Push with pop at count=1: count stays 1, the head advances to the new entry, and order is preserved.
  - Push with pop at count=0: impossible, since pop requires out_valid.
  - At count=2, in_ready=0, so a pop only drains. in_valid is ignored and the data is not captured; the upstream must hold it.
- Output stability: while out_valid=1 and out_ready=0, out_y, out_flags and out_sel are stable.
- Sticky flags, updated on push only:
  - sticky_cout |= in_cout; sticky_ovf |= in_ovf.
  - clr_sticky clears both the same edge.
  - If clr_sticky coincides with a push carrying a set flag, the set wins (flag=1 after the edge).
  - Flags are taken from the ALU regardless of sel. Logic ops drive Overflow=0, so they do not set sticky_ovf.
- result_cnt increments on push and saturates at 2^CNT_W−1 (it does not wrap). clr_sticky does not affect it; only reset clears it.

Test Plan:
- Reset then single push: in_y=32'h0000_00A5, flags Cout=0 N=0 Z=0 V=0, sel=4'b0000, out_ready=1 → next cycle out_valid=1, out_y=32'h0000_00A5, out_flags=4'b0000, out_sel=0; following cycle out_valid=0; result_cnt=1.
- Backpressure: out_ready=0, push 3 consecutive values 1,2,3 with in_valid held → after two pushes in_ready=0 and value 3 is held; raise out_ready → outputs 1,2,3 in order; result_cnt=3.
- Simultaneous push/pop at count=1, continuous streaming of 8 values with out_ready=1 → one output per cycle, in order, in_ready stays 1, count never exceeds 1.
- Sticky: push an entry with Overflow=1 (e.g. 32'h7FFF_FFFF+1 result 32'h8000_0000, N=1, V=1) → sticky_ovf=1; push one with V=0 → stays 1; clr_sticky for one cycle → 0; clr_sticky coincident with a V=1 push → 1.
- Saturation with CNT_W=4: push 20 entries → result_cnt=4'hF and holds.
- Async reset mid-operation: with 2 entries buffered, pulse rst_n low between edges → out_valid=0, in_ready=1, stickies=0 and result_cnt=0 immediately, without waiting for a clock edge.
